// File: rtl/micro_step_sequencer_pkg.sv
// Shared encodings for the micro-step sequencer: FSM states, flag bit positions, NOP opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package micro_step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    localparam int CARRY_BIT = 0;
    localparam int ZERO_BIT  = 1;

    // Opcode held in the IR after reset; the low nibble is also zero, so IR resets to 8'h00.
    localparam logic [3:0] NOP_OPCODE = 4'h0;

endpackage

// File: rtl/micro_step_sequencer_step_edge_detect.sv
// Rising-edge detector for the single-step request.
// Latency: pulse is high in the first cycle the request is seen high (combinational from a 1-deep history reg).
// Backpressure: none; a request held high produces exactly one pulse.
module step_edge_detect (
    input  logic CLK,
    input  logic Reset_n,
    input  logic step_req,
    output logic step_pulse
);

    logic step_req_q;

    // Remember last cycle's request level so a held request only fires once.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            step_req_q <= 1'b0;
        end else begin
            step_req_q <= step_req;
        end
    end

    assign step_pulse = step_req & ~step_req_q;

endmodule

// File: rtl/micro_step_sequencer.sv
// Micro-step counter, IR and ALU flag latch, with run / single-step / halt control, feeding the microcode decoder.
// Latency: every output is registered; inputs sampled at an edge are visible after that edge.
// Backpressure: Halt_Signal freezes the count on the edge it is sampled; Resume_Request restarts at step 0.
module micro_step_sequencer
    import micro_step_sequencer_pkg::*;
#(
    parameter logic [2:0] LAST_STEP = 3'd4,
    parameter int         DATA_W    = 8,
    parameter int         RETIRE_W  = 16
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic                Run_Enable,
    input  logic                Step_Request,
    input  logic                Resume_Request,
    input  logic                Halt_Signal,
    input  logic                Instruction_Reg_In,
    input  logic [DATA_W-1:0]   Data_Bus,
    input  logic                ALU_Flags_Out,
    input  logic                ALU_Carry,
    input  logic                ALU_Zero,
    input  logic                Clear_Carry,
    input  logic                Clear_Zero,
    output logic [2:0]          Micro_Count,
    output logic [3:0]          Instruction_OpCode,
    output logic [3:0]          Instruction_Operand,
    output logic [7:0]          ALU_Flags,
    output logic                Halted,
    output logic [RETIRE_W-1:0] Retired_Count
);

    localparam logic [DATA_W-1:0] IR_RESET = {NOP_OPCODE, {(DATA_W-4){1'b0}}};

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic                advance;
    logic                resume_fire;
    logic                step_pulse;
    logic                active;
    logic [2:0]          count_q;
    logic [DATA_W-1:0]   ir_q;
    logic [1:0]          flags_q;
    logic                halted_q;
    logic [RETIRE_W-1:0] retired_q;

    step_edge_detect u_step_edge (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .step_req   (Step_Request),
        .step_pulse (step_pulse)
    );

    assign active = (state_q != ST_HALTED);

    // Next state and advance; Halt_Signal also masks advance in the cycle it is sampled so the
    // halting instruction's step stays on Micro_Count (decoder outputs lag the count by one cycle).
    always_comb begin
        state_d     = state_q;
        advance     = 1'b0;
        resume_fire = 1'b0;
        case (state_q)
            ST_RUN: begin
                advance = 1'b1;
                if (Halt_Signal) begin
                    state_d = ST_HALTED;
                end else if (!Run_Enable) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                advance = step_pulse;
                if (Halt_Signal) begin
                    state_d = ST_HALTED;
                end else if (Run_Enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (Resume_Request && !Halt_Signal) begin
                    resume_fire = 1'b1;
                    state_d     = Run_Enable ? ST_RUN : ST_STEP;
                end
            end
            default: begin
                state_d = Run_Enable ? ST_RUN : ST_STEP;
            end
        endcase
        if (Halt_Signal) begin
            advance = 1'b0;
        end
    end

    // State register; reset lands directly in RUN or STEP according to the Run_Enable level.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= Run_Enable ? ST_RUN : ST_STEP;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    // Micro-step counter and retired-instruction count; a resume restarts at the next fetch (step 0).
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q   <= 3'd0;
            retired_q <= '0;
        end else if (resume_fire) begin
            count_q <= 3'd0;
        end else if (advance) begin
            if (count_q >= LAST_STEP) begin
                count_q <= 3'd0;
                if (retired_q != {RETIRE_W{1'b1}}) begin
                    retired_q <= retired_q + 1'b1;
                end
            end else begin
                count_q <= count_q + 3'd1;
            end
        end
    end

    // Instruction register: loads whenever the decoder strobes it, except while halted.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_q <= IR_RESET;
        end else if (active && Instruction_Reg_In) begin
            ir_q <= Data_Bus;
        end
    end

    // Flag latch: a fresh ALU result overrides a same-cycle branch clear; frozen while halted.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            flags_q <= 2'b00;
        end else if (active) begin
            if (ALU_Flags_Out) begin
                flags_q[CARRY_BIT] <= ALU_Carry;
                flags_q[ZERO_BIT]  <= ALU_Zero;
            end else begin
                if (Clear_Carry) begin
                    flags_q[CARRY_BIT] <= 1'b0;
                end
                if (Clear_Zero) begin
                    flags_q[ZERO_BIT] <= 1'b0;
                end
            end
        end
    end

    assign Micro_Count         = count_q;
    assign Instruction_OpCode  = ir_q[DATA_W-1 -: 4];
    assign Instruction_Operand = ir_q[3:0];
    assign ALU_Flags           = {6'b000000, flags_q};
    assign Halted              = halted_q;
    assign Retired_Count       = retired_q;

endmodule
